// File: rtl/rgb_stream_bridge.sv
// ============================================================================
//  Module      : rgb_stream_bridge
//  Description : Host Avalon-MM pixel writes -> framed Avalon-ST stream, and
//                returned depth stream -> auto-addressed on-chip memory writes.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module rgb_stream_bridge #(
  parameter int DATA_W      = 8,
  parameter int CHANNELS    = 3,
  parameter int LINE_LEN    = 320,
  parameter int FRAME_LINES = 240,
  parameter int FIFO_DEPTH  = 16,
  parameter int RES_W       = 8,
  parameter int RES_DEPTH   = 76800,
  parameter int RES_ADDR_W  = 17
) (
  input  logic                           reconfig_xcvr_clk,
  input  logic                           any_rstn,
  input  logic                           clear,
  // host pixel window
  input  logic                           mm_write,
  input  logic                           mm_chipselect,
  input  logic [31:0]                    mm_writedata,
  output logic                           mm_waitrequest,
  // pixel stream
  output logic [CHANNELS*DATA_W-1:0]     st_data,
  output logic                           st_valid,
  input  logic                           st_ready,
  output logic                           st_sop,
  output logic                           st_eop,
  output logic                           st_sof,
  output logic                           st_eof,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_level,
  // result stream
  input  logic                           res_valid,
  input  logic [RES_W-1:0]               res_data,
  // result memory window
  output logic                           mem_write,
  output logic                           mem_chipselect,
  output logic                           mem_clken,
  output logic [RES_ADDR_W-1:0]          mem_address,
  output logic [31:0]                    mem_writedata,
  output logic [3:0]                     mem_byteenable,
  output logic                           res_frame_done
);

  localparam int c_pix_w = CHANNELS * DATA_W;
  localparam int c_aw    = $clog2(FIFO_DEPTH);
  localparam int c_col_w = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
  localparam int c_row_w = (FRAME_LINES > 1) ? $clog2(FRAME_LINES) : 1;

  localparam logic [c_aw:0]       c_full_level = (c_aw + 1)'(FIFO_DEPTH);
  localparam logic [c_col_w-1:0]  c_col_last   = c_col_w'(LINE_LEN - 1);
  localparam logic [c_row_w-1:0]  c_row_last   = c_row_w'(FRAME_LINES - 1);
  localparam logic [RES_ADDR_W-1:0] c_res_last = RES_ADDR_W'(RES_DEPTH - 1);

  // --------------------------------------------------------------------------
  // Reset synchroniser: asserts immediately, releases after two edges
  // --------------------------------------------------------------------------
  logic r_rst_r;
  logic r_rst_rr;
  logic w_rst;

  always_ff @(posedge reconfig_xcvr_clk or negedge any_rstn) begin
    if (!any_rstn) begin
      r_rst_r  <= 1'b0;
      r_rst_rr <= 1'b0;
    end else begin
      r_rst_r  <= 1'b1;
      r_rst_rr <= r_rst_r;
    end
  end

  assign w_rst = ~r_rst_rr;

  // --------------------------------------------------------------------------
  // Ingress FIFO
  // --------------------------------------------------------------------------
  logic [c_pix_w-1:0] r_fifo_mem [FIFO_DEPTH];
  logic [c_aw-1:0]    r_wr_ptr;
  logic [c_aw-1:0]    r_rd_ptr;
  logic [c_aw:0]      r_level;
  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;

  assign w_full         = (r_level == c_full_level);
  assign w_empty        = (r_level == '0);
  assign mm_waitrequest = w_rst | w_full | clear;
  assign w_push         = mm_write & mm_chipselect & ~mm_waitrequest;
  // clear wins over a pop offered in the same cycle
  assign w_pop          = ~w_empty & st_ready & ~clear;

  // Storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge reconfig_xcvr_clk) begin
    if (w_push) begin
      r_fifo_mem[r_wr_ptr] <= mm_writedata[c_pix_w-1:0];
    end
  end

  always_ff @(posedge reconfig_xcvr_clk or negedge any_rstn) begin
    if (!any_rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (w_rst || clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  assign fifo_level = r_level;
  assign st_valid   = ~w_empty;
  assign st_data    = st_valid ? r_fifo_mem[r_rd_ptr] : '0;

  generate
    if (c_pix_w < 32) begin : g_pix_unused
      logic w_unused_hi;
      assign w_unused_hi = &{1'b0, mm_writedata[31:c_pix_w]};
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Frame geometry, advanced only by accepted stream beats
  // --------------------------------------------------------------------------
  logic [c_col_w-1:0] r_col;
  logic [c_row_w-1:0] r_row;
  logic               w_col_last;
  logic               w_row_last;

  assign w_col_last = (r_col == c_col_last);
  assign w_row_last = (r_row == c_row_last);

  always_ff @(posedge reconfig_xcvr_clk or negedge any_rstn) begin
    if (!any_rstn) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_rst || clear) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_pop) begin
      if (w_col_last) begin
        r_col <= '0;
        r_row <= w_row_last ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  assign st_sop = st_valid & (r_col == '0);
  assign st_eop = st_valid & w_col_last;
  assign st_sof = st_sop & (r_row == '0);
  assign st_eof = st_eop & w_row_last;

  // --------------------------------------------------------------------------
  // Result path: one register stage, address follows completed writes
  // --------------------------------------------------------------------------
  logic                  r_mem_write;
  logic [RES_W-1:0]      r_res_data;
  logic [RES_ADDR_W-1:0] r_res_addr;
  logic                  w_res_accept;
  logic                  w_addr_last;

  assign w_res_accept = res_valid & ~clear;
  assign w_addr_last  = (r_res_addr == c_res_last);

  always_ff @(posedge reconfig_xcvr_clk or negedge any_rstn) begin
    if (!any_rstn) begin
      r_mem_write <= 1'b0;
      r_res_data  <= '0;
      r_res_addr  <= '0;
    end else if (w_rst) begin
      r_mem_write <= 1'b0;
      r_res_data  <= '0;
      r_res_addr  <= '0;
    end else begin
      r_mem_write <= w_res_accept;
      if (w_res_accept) begin
        r_res_data <= res_data;
      end
      // a write already in the output register still lands at its own address
      if (clear) begin
        r_res_addr <= '0;
      end else if (r_mem_write) begin
        r_res_addr <= w_addr_last ? '0 : r_res_addr + 1'b1;
      end
    end
  end

  assign mem_write      = r_mem_write;
  assign mem_chipselect = r_mem_write;
  assign mem_clken      = r_mem_write;
  assign mem_address    = r_res_addr;
  assign mem_byteenable = 4'b0001;
  assign res_frame_done = r_mem_write & w_addr_last;

  generate
    if (RES_W < 32) begin : g_res_pad
      assign mem_writedata = {{(32 - RES_W){1'b0}}, r_res_data};
    end else begin : g_res_full
      assign mem_writedata = r_res_data[31:0];
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_rgb_stream_bridge.sv
// ============================================================================
//  Module      : tb_rgb_stream_bridge
//  Description : Scoreboard bench for rgb_stream_bridge with a queue-based model.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rgb_stream_bridge;

  localparam int DATA_W      = 8;
  localparam int CHANNELS    = 3;
  localparam int LINE_LEN    = 4;
  localparam int FRAME_LINES = 2;
  localparam int FIFO_DEPTH  = 16;
  localparam int RES_W       = 8;
  localparam int RES_DEPTH   = 6;
  localparam int RES_ADDR_W  = 3;
  localparam int PIX_W       = DATA_W * CHANNELS;

  logic                  clk = 1'b0;
  logic                  any_rstn = 1'b1;
  logic                  clear = 1'b0;
  logic                  mm_write = 1'b0;
  logic                  mm_chipselect = 1'b0;
  logic [31:0]           mm_writedata = '0;
  logic                  mm_waitrequest;
  logic [PIX_W-1:0]      st_data;
  logic                  st_valid;
  logic                  st_ready = 1'b0;
  logic                  st_sop, st_eop, st_sof, st_eof;
  logic [4:0]            fifo_level;
  logic                  res_valid = 1'b0;
  logic [RES_W-1:0]      res_data = '0;
  logic                  mem_write, mem_chipselect, mem_clken;
  logic [RES_ADDR_W-1:0] mem_address;
  logic [31:0]           mem_writedata;
  logic [3:0]            mem_byteenable;
  logic                  res_frame_done;

  rgb_stream_bridge #(
    .DATA_W(DATA_W), .CHANNELS(CHANNELS), .LINE_LEN(LINE_LEN),
    .FRAME_LINES(FRAME_LINES), .FIFO_DEPTH(FIFO_DEPTH), .RES_W(RES_W),
    .RES_DEPTH(RES_DEPTH), .RES_ADDR_W(RES_ADDR_W)
  ) dut (
    .reconfig_xcvr_clk(clk), .any_rstn(any_rstn), .clear(clear),
    .mm_write(mm_write), .mm_chipselect(mm_chipselect),
    .mm_writedata(mm_writedata), .mm_waitrequest(mm_waitrequest),
    .st_data(st_data), .st_valid(st_valid), .st_ready(st_ready),
    .st_sop(st_sop), .st_eop(st_eop), .st_sof(st_sof), .st_eof(st_eof),
    .fifo_level(fifo_level), .res_valid(res_valid), .res_data(res_data),
    .mem_write(mem_write), .mem_chipselect(mem_chipselect),
    .mem_clken(mem_clken), .mem_address(mem_address),
    .mem_writedata(mem_writedata), .mem_byteenable(mem_byteenable),
    .res_frame_done(res_frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PIX_W-1:0] data;
    logic [3:0]       flags;   // {sop, eop, sof, eof}
  } px_t;

  typedef struct {
    int                    due;
    logic [RES_ADDR_W-1:0] addr;
    logic [31:0]           data;
    logic                  done;
  } rs_t;

  px_t exp_q[$];
  rs_t res_q[$];
  int  vectors    = 0;
  int  miscompares = 0;
  int  cycle      = 0;
  int  push_idx   = 0;
  int  res_idx    = 0;
  bit  tb_in_rst  = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  always @(posedge clk) cycle++;

  // Model + monitor: compare what the DUT shows now, then apply this edge's
  // handshakes to the model queues.
  always @(negedge clk) begin : mon
    px_t  e;
    rs_t  r;
    logic exp_wait;
    logic acc;
    logic xfer;
    int   col;
    int   row;
    exp_wait = tb_in_rst || (exp_q.size() == FIFO_DEPTH) || clear;
    chk("waitrequest", mm_waitrequest, exp_wait);
    chk("fifo_level", fifo_level, exp_q.size());
    if (exp_q.size() == 0) begin
      chk("st_valid_idle", st_valid, 0);
      chk("flags_idle", {st_sop, st_eop, st_sof, st_eof}, 0);
      chk("st_data_idle", st_data, 0);
    end else begin
      e = exp_q[0];
      chk("st_valid", st_valid, 1);
      chk("st_data", st_data, e.data);
      chk("flags", {st_sop, st_eop, st_sof, st_eof}, e.flags);
    end
    xfer = (exp_q.size() != 0) && st_ready && !clear;
    acc  = mm_write && mm_chipselect && !exp_wait;
    if (xfer) void'(exp_q.pop_front());
    if (acc) begin
      col = push_idx % LINE_LEN;
      row = (push_idx / LINE_LEN) % FRAME_LINES;
      e.data  = mm_writedata[PIX_W-1:0];
      e.flags = {col == 0, col == LINE_LEN - 1,
                 col == 0 && row == 0,
                 col == LINE_LEN - 1 && row == FRAME_LINES - 1};
      exp_q.push_back(e);
      push_idx++;
    end
    if (clear) begin
      exp_q.delete();
      push_idx = 0;
    end

    if (res_q.size() != 0 && res_q[0].due <= cycle) begin
      r = res_q.pop_front();
      chk("mem_write", mem_write, 1);
      chk("mem_chipselect", mem_chipselect, 1);
      chk("mem_clken", mem_clken, 1);
      chk("mem_address", mem_address, r.addr);
      chk("mem_writedata", mem_writedata, r.data);
      chk("res_frame_done", res_frame_done, r.done);
    end else begin
      chk("mem_write_idle", mem_write, 0);
      chk("mem_clken_idle", mem_clken, 0);
      chk("res_frame_done_idle", res_frame_done, 0);
    end
    chk("mem_byteenable", mem_byteenable, 4'b0001);
    if (res_valid && !clear && !tb_in_rst) begin
      r.due  = cycle + 1;
      r.addr = RES_ADDR_W'(res_idx % RES_DEPTH);
      r.data = {24'h0, res_data};
      r.done = (res_idx % RES_DEPTH) == RES_DEPTH - 1;
      res_q.push_back(r);
      res_idx++;
    end
    if (clear) res_idx = 0;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs();
    chk("rst_st_valid", st_valid, 0);
    chk("rst_st_data", st_data, 0);
    chk("rst_flags", {st_sop, st_eop, st_sof, st_eof}, 0);
    chk("rst_fifo_level", fifo_level, 0);
    chk("rst_waitrequest", mm_waitrequest, 1);
    chk("rst_mem_write", {mem_write, mem_chipselect, mem_clken}, 0);
    chk("rst_mem_address", mem_address, 0);
    chk("rst_mem_writedata", mem_writedata, 0);
    chk("rst_byteenable", mem_byteenable, 4'b0001);
    chk("rst_frame_done", res_frame_done, 0);
  endtask

  // Called at posedge+1; asserts any_rstn asynchronously mid-cycle.
  task automatic do_reset();
    mm_write  = 1'b0;
    res_valid = 1'b0;
    clear     = 1'b0;
    tb_in_rst = 1'b1;
    #2;
    any_rstn = 1'b0;
    exp_q.delete();
    res_q.delete();
    push_idx = 0;
    res_idx  = 0;
    #1;
    check_reset_outputs();
    repeat (3) tick();
    any_rstn = 1'b1;
    tick();
    tick();
    tb_in_rst = 1'b0;
  endtask

  task automatic host_write(input logic [31:0] d);
    int n;
    mm_write      = 1'b1;
    mm_chipselect = 1'b1;
    mm_writedata  = d;
    n = 0;
    @(negedge clk);
    while (mm_waitrequest && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) begin
      vectors++;
      miscompares++;
      $display("FAIL host_write_timeout: got waitrequest=1 required 0 within 200 cycles");
    end
    tick();
    mm_write = 1'b0;
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: got %0d queued required 0", exp_q.size());
    end
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got no finish required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    #1;
    do_reset();

    // framing: two lines of four pixels
    st_ready = 1'b1;
    for (int i = 1; i <= 8; i++) host_write(32'(i));
    wait_empty();

    // backpressure: fill to full, then release
    st_ready = 1'b0;
    for (int i = 1; i <= FIFO_DEPTH; i++) host_write(32'h100 + 32'(i));
    tick();
    chk("full_level", fifo_level, FIFO_DEPTH);
    chk("full_wait", mm_waitrequest, 1);
    st_ready = 1'b1;
    host_write(32'h111);
    host_write(32'h112);
    wait_empty();

    // concurrent push/pop at level 5
    st_ready = 1'b0;
    for (int i = 0; i < 5; i++) host_write(32'h200 + 32'(i));
    st_ready = 1'b1;
    for (int i = 0; i < 20; i++) host_write(32'h300 + 32'(i));
    st_ready = 1'b0;
    chk("concurrent_level", fifo_level, 5);
    st_ready = 1'b1;
    wait_empty();

    // result wrap over eight words
    pulse_clear();
    res_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      res_data = RES_W'($urandom);
      tick();
    end
    res_valid = 1'b0;
    tick();

    // clear at level 7, col 3, with a push and a result write racing it
    pulse_clear();
    st_ready = 1'b1;
    for (int i = 0; i < 3; i++) host_write(32'h400 + 32'(i));
    wait_empty();
    st_ready = 1'b0;
    for (int i = 0; i < 7; i++) host_write(32'h500 + 32'(i));
    res_valid = 1'b1;
    res_data  = 8'hA5;
    tick();
    clear         = 1'b1;
    res_data      = 8'h5A;
    mm_write      = 1'b1;
    mm_chipselect = 1'b1;
    mm_writedata  = 32'hDEAD;
    tick();
    clear     = 1'b0;
    mm_write  = 1'b0;
    res_valid = 1'b1;
    res_data  = 8'h3C;
    chk("clear_level", fifo_level, 0);
    tick();
    res_valid = 1'b0;
    st_ready  = 1'b1;
    host_write(32'h600);
    wait_empty();

    // randomized traffic with occasional clears and one mid-stream reset
    for (int i = 0; i < 600; i++) begin
      mm_write      = ($urandom_range(0, 3) != 0);
      mm_chipselect = ($urandom_range(0, 4) != 0);
      mm_writedata  = $urandom;
      st_ready      = ($urandom_range(0, 2) != 0);
      res_valid     = $urandom_range(0, 1) == 1;
      res_data      = RES_W'($urandom);
      clear         = ($urandom_range(0, 59) == 0);
      if (i == 300) do_reset();
      else tick();
    end
    mm_write  = 1'b0;
    res_valid = 1'b0;
    clear     = 1'b0;
    st_ready  = 1'b1;
    wait_empty();
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
